ps2_kb_uart_monitor: RTL and testbench

- Receives PS/2 keyboard frames on `ps2c`/`ps2d`.
- Decodes Scan Code Set 2 make codes into ASCII.
- Transmits each ASCII byte on a UART line (`tx`), 8N1.
- Sits between the board's PS/2 connector and a host serial port, for debugging and monitoring keyboard input.

---
 rtl/ps2_kb_uart_monitor.sv | 203 ++++++++++++++++++++
 tb/tb_ps2_kb_uart_monitor.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kb_uart_monitor.sv
// ps2_kb_uart_monitor: decodes PS/2 Scan Code Set 2 make codes to ASCII and echoes them on an 8N1 UART.
// Path: synchronise/filter ps2c -> 11-bit frame receiver -> make/break filter -> byte FIFO -> UART transmitter.
module ps2_kb_uart_monitor #(
  parameter int CLKS_PER_BIT = 2604,
  parameter int PS2_TIMEOUT  = 50000,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2d,
  input  logic ps2c,
  output logic tx
);
  localparam int TW = $clog2(PS2_TIMEOUT + 1);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {RX_IDLE, RX_RECV} rx_state_e;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;

  logic [1:0] c_sync_q, d_sync_q;
  logic [7:0] c_sr_q;
  logic       c_filt_q, c_filt_d, fall;

  // PS/2 lines idle high; resetting the conditioning chain to 1 avoids a phantom edge after reset
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      c_sync_q <= 2'b11;
      d_sync_q <= 2'b11;
      c_sr_q   <= '1;
      c_filt_q <= 1'b1;
    end else begin
      c_sync_q <= {c_sync_q[0], ps2c};
      d_sync_q <= {d_sync_q[0], ps2d};
      c_sr_q   <= {c_sr_q[6:0], c_sync_q[1]};
      c_filt_q <= c_filt_d;
    end

  assign c_filt_d = &c_sr_q ? 1'b1 : ~|c_sr_q ? 1'b0 : c_filt_q;
  assign fall     = c_filt_q & ~c_filt_d;

  rx_state_e     rx_state_q, rx_state_d;
  logic [9:0]    rx_sr_q, rx_sr_d;
  logic [3:0]    rx_cnt_q, rx_cnt_d;
  logic [TW-1:0] rx_tmr_q, rx_tmr_d;
  logic [10:0]   frame;
  logic [7:0]    rx_code;
  logic          rx_last, rx_tout, rx_done;

  assign rx_last = fall && rx_cnt_q == 4'd10;
  assign rx_tout = !fall && rx_tmr_q == TW'(PS2_TIMEOUT - 1);

  always_ff @(posedge clk or negedge reset)
    if (!reset) rx_state_q <= RX_IDLE;
    else rx_state_q <= rx_state_d;

  always_comb
    rx_state_d = rx_state_q == RX_IDLE ? (fall ? RX_RECV : RX_IDLE)
                                       : (rx_last || rx_tout ? RX_IDLE : RX_RECV);

  // the frame is the ten stored samples plus the bit arriving on the 11th fall
  always_comb begin
    frame    = {d_sync_q[1], rx_sr_q};
    rx_sr_d  = fall ? frame[10:1] : rx_sr_q;
    rx_cnt_d = rx_state_d == RX_IDLE ? 4'd0 : fall ? rx_cnt_q + 4'd1 : rx_cnt_q;
    rx_tmr_d = rx_state_q == RX_IDLE || fall ? '0 : rx_tmr_q + TW'(1);
    rx_done  = rx_state_q == RX_RECV && rx_last && !frame[0] && frame[10];
    rx_code  = frame[8:1];
  end

  logic       brk_q, brk_d, ext_q, ext_d, push;
  logic [7:0] ascii;

  always_comb begin
    push  = rx_done && rx_code != 8'hE0 && rx_code != 8'hF0 && !brk_q;
    brk_d = rx_done ? rx_code == 8'hF0 || (rx_code == 8'hE0 && brk_q) : brk_q;
    ext_d = rx_done ? rx_code == 8'hE0 || (rx_code == 8'hF0 && ext_q) : ext_q;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rx_sr_q  <= '0;
      rx_cnt_q <= '0;
      rx_tmr_q <= '0;
      brk_q    <= 1'b0;
      ext_q    <= 1'b0;
    end else begin
      rx_sr_q  <= rx_sr_d;
      rx_cnt_q <= rx_cnt_d;
      rx_tmr_q <= rx_tmr_d;
      brk_q    <= brk_d;
      ext_q    <= ext_d;
    end

  always_comb
    case (rx_code)
      8'h45: ascii = 8'h30;
      8'h16: ascii = 8'h31;
      8'h1E: ascii = 8'h32;
      8'h26: ascii = 8'h33;
      8'h25: ascii = 8'h34;
      8'h2E: ascii = 8'h35;
      8'h36: ascii = 8'h36;
      8'h3D: ascii = 8'h37;
      8'h3E: ascii = 8'h38;
      8'h46: ascii = 8'h39;
      8'h1C: ascii = 8'h41;
      8'h32: ascii = 8'h42;
      8'h21: ascii = 8'h43;
      8'h23: ascii = 8'h44;
      8'h24: ascii = 8'h45;
      8'h2B: ascii = 8'h46;
      8'h34: ascii = 8'h47;
      8'h33: ascii = 8'h48;
      8'h43: ascii = 8'h49;
      8'h3B: ascii = 8'h4A;
      8'h42: ascii = 8'h4B;
      8'h4B: ascii = 8'h4C;
      8'h3A: ascii = 8'h4D;
      8'h31: ascii = 8'h4E;
      8'h44: ascii = 8'h4F;
      8'h4D: ascii = 8'h50;
      8'h15: ascii = 8'h51;
      8'h2D: ascii = 8'h52;
      8'h1B: ascii = 8'h53;
      8'h2C: ascii = 8'h54;
      8'h3C: ascii = 8'h55;
      8'h2A: ascii = 8'h56;
      8'h1D: ascii = 8'h57;
      8'h22: ascii = 8'h58;
      8'h35: ascii = 8'h59;
      8'h1A: ascii = 8'h5A;
      8'h29: ascii = 8'h20;
      8'h5A: ascii = 8'h0D;
      default: ascii = 8'h2A;
    endcase

  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [NW-1:0] cnt_q;
  logic          pop, empty, wr_en, rd_en;

  assign empty = cnt_q == '0;
  assign rd_en = pop && !empty;
  // a full FIFO still accepts a push in a cycle that also pops
  assign wr_en = push && (cnt_q != NW'(FIFO_DEPTH) || rd_en);

  always_ff @(posedge clk)
    if (wr_en) fifo_q[wr_q] <= ascii;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_en ? (wr_q == PW'(FIFO_DEPTH - 1) ? '0 : wr_q + PW'(1)) : wr_q;
      rd_q  <= rd_en ? (rd_q == PW'(FIFO_DEPTH - 1) ? '0 : rd_q + PW'(1)) : rd_q;
      cnt_q <= cnt_q + NW'(wr_en) - NW'(rd_en);
    end

  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_clk_q, tx_clk_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [8:0]    tx_sh_q, tx_sh_d;
  logic          tx_q, tx_d, bit_end, load;

  assign bit_end = tx_state_q == TX_SEND && tx_clk_q == CW'(CLKS_PER_BIT - 1);

  always_ff @(posedge clk or negedge reset)
    if (!reset) tx_state_q <= TX_IDLE;
    else tx_state_q <= tx_state_d;

  always_comb
    tx_state_d = tx_state_q == TX_IDLE ? (empty ? TX_IDLE : TX_SEND)
                                       : (bit_end && tx_bit_q == 4'd9 && empty ? TX_IDLE : TX_SEND);

  // the shifter refills with 1s, so the stop bit falls out after d7
  always_comb begin
    load     = !empty && (tx_state_q == TX_IDLE || (bit_end && tx_bit_q == 4'd9));
    pop      = load;
    tx_clk_d = load || bit_end || tx_state_q == TX_IDLE ? '0 : tx_clk_q + CW'(1);
    tx_bit_d = load || tx_state_d == TX_IDLE ? 4'd0 : bit_end ? tx_bit_q + 4'd1 : tx_bit_q;
    tx_sh_d  = load ? {1'b1, fifo_q[rd_q]} : bit_end ? {1'b1, tx_sh_q[8:1]} : tx_sh_q;
    tx_d     = load ? 1'b0 : tx_state_d == TX_IDLE ? 1'b1 : bit_end ? tx_sh_q[0] : tx_q;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tx_clk_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '1;
      tx_q     <= 1'b1;
    end else begin
      tx_clk_q <= tx_clk_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q  <= tx_sh_d;
      tx_q     <= tx_d;
    end

  assign tx = tx_q;
endmodule

// File: tb/tb_ps2_kb_uart_monitor.sv
// tb_ps2_kb_uart_monitor: drives PS/2 frames, decodes the UART line and compares against a code-level model.
module tb_ps2_kb_uart_monitor;
  localparam int CPB  = 160;
  localparam int TOUT = 200;
  localparam int HALF = 12;
  localparam int BYTE = 10 * CPB;
  localparam int NV   = 9;
  localparam logic [7:0] DIG [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  localparam logic [7:0] ALPHA [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D,
    8'h22, 8'h35, 8'h1A};

  typedef struct {
    logic [7:0] code;
    logic [7:0] ascii;
  } vec_t;

  logic clk = 0, reset = 1, ps2d = 1, ps2c = 1, tx;
  int cyc = 0, total = 0, passed = 0, last_fall = 0;
  logic [7:0] rx_q[$], exp_q[$];
  int st_q[$];
  bit m_brk = 0;
  vec_t vecs[NV];

  ps2_kb_uart_monitor #(.CLKS_PER_BIT(CPB), .PS2_TIMEOUT(TOUT), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .tx(tx));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic int rx_at(input int i);
    return i < rx_q.size() ? int'(rx_q[i]) : -1;
  endfunction

  function automatic int st_at(input int i);
    return i < st_q.size() ? st_q[i] : -100000;
  endfunction

  function automatic logic [7:0] xlate(input logic [7:0] c);
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    for (int i = 0; i < 10; i++) if (DIG[i] == c) return 8'h30 + 8'(i);
    for (int i = 0; i < 26; i++) if (ALPHA[i] == c) return 8'h41 + 8'(i);
    return 8'h2A;
  endfunction

  task automatic model_code(input logic [7:0] c);
    if (c == 8'hF0) m_brk = 1;
    else if (c == 8'hE0) m_brk = m_brk;
    else if (m_brk) m_brk = 0;
    else exp_q.push_back(xlate(c));
  endtask

  // device-style timing: data changes mid-way through the clock-high phase
  task automatic send_frame(input logic [7:0] code, input bit bad_stop = 0, input int nbits = 11);
    logic [10:0] f;
    f = {~bad_stop, ~^code, code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      repeat (HALF / 2) @(negedge clk);
      ps2d = f[i];
      repeat (HALF - HALF / 2) @(negedge clk);
      ps2c = 0;
      last_fall = cyc;
      repeat (HALF) @(negedge clk);
      ps2c = 1;
    end
    repeat (HALF) @(negedge clk);
    ps2d = 1;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int t;
    t = 0;
    while (rx_q.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
  endtask

  // UART decoder: every bit must hold one level for exactly CPB clocks
  initial begin
    bit prev, stable, aborted;
    logic [9:0] bits;
    int t0;
    prev = 1;
    forever begin
      @(negedge clk);
      if (reset && prev && !tx) begin
        t0 = cyc;
        stable = 1;
        aborted = 0;
        for (int i = 0; i < BYTE; i++) begin
          if (i > 0) @(negedge clk);
          if (!reset) begin
            aborted = 1;
            break;
          end
          if (i % CPB == 0) bits[i / CPB] = tx;
          else if (tx !== bits[i / CPB]) stable = 0;
        end
        if (!aborted) begin
          check("uart_frame", {stable, bits[0], bits[9]}, 3'b101);
          rx_q.push_back(bits[8:1]);
          st_q.push_back(t0);
        end
      end
      prev = reset ? tx : 1'b1;
    end
  end

  initial begin
    int n, low;
    logic [7:0] c;
    logic [7:0] seq[$];
    vecs = '{'{8'h16, 8'h31}, '{8'h46, 8'h39}, '{8'h1C, 8'h41}, '{8'h1A, 8'h5A}, '{8'h4D, 8'h50},
             '{8'h29, 8'h20}, '{8'h5A, 8'h0D}, '{8'h76, 8'h2A}, '{8'h00, 8'h2A}};
    #2 reset = 0;
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1);
    reset = 1;
    repeat (50) @(negedge clk);
    check("idle_tx", tx, 1);

    send_frame(8'h45);
    wait_bytes(1, 2 * BYTE);
    check("byte_45", rx_at(0), 8'h30);
    check("latency", (st_at(0) - last_fall) <= 52, 1);

    for (int i = 0; i < NV; i++) begin
      n = rx_q.size();
      send_frame(vecs[i].code);
      wait_bytes(n + 1, 2 * BYTE);
      check($sformatf("vec%0d_%02h", i, vecs[i].code), rx_at(n), vecs[i].ascii);
    end

    n = rx_q.size();
    send_frame(8'h1C);
    send_frame(8'hF0);
    send_frame(8'h1C);
    wait_bytes(n + 2, BYTE + BYTE / 2);
    check("release_count", rx_q.size() - n, 1);
    check("release_byte", rx_at(n), 8'h41);

    n = rx_q.size();
    send_frame(8'h76);
    send_frame(8'h29);
    wait_bytes(n + 2, 3 * BYTE);
    check("b2b_first", rx_at(n), 8'h2A);
    check("b2b_second", rx_at(n + 1), 8'h20);
    check("b2b_gap", st_at(n + 1) - st_at(n), BYTE);

    n = rx_q.size();
    send_frame(8'h1C, 1);
    send_frame(8'h55, 0, 6);
    repeat (2 * TOUT) @(negedge clk);
    send_frame(8'h16);
    wait_bytes(n + 2, 2 * BYTE);
    check("bad_frame_count", rx_q.size() - n, 1);
    check("after_bad_byte", rx_at(n), 8'h31);

    n = rx_q.size();
    foreach (DIG[i]) if (i >= 1 && i <= 6) send_frame(DIG[i]);
    wait_bytes(n + 6, 6 * BYTE);
    check("overflow_count", rx_q.size() - n, 5);
    for (int k = 0; k < 5; k++) check($sformatf("overflow_byte%0d", k), rx_at(n + k), 8'h31 + k);
    check("overflow_gap", st_at(n + 4) - st_at(n + 3), BYTE);

    n = rx_q.size();
    for (int e = 0; e < 10; e++) begin
      if ($urandom_range(0, 1)) c = ALPHA[$urandom_range(0, 25)];
      else begin
        c = 8'($urandom_range(0, 255));
        while (c == 8'hE0 || c == 8'hF0) c = 8'($urandom_range(0, 255));
      end
      seq.delete();
      case ($urandom_range(0, 3))
        1: seq = '{8'hF0, c};
        2: seq = '{8'hE0, c};
        3: seq = '{8'hE0, 8'hF0, c};
        default: seq = '{c};
      endcase
      foreach (seq[j]) begin
        model_code(seq[j]);
        send_frame(seq[j]);
      end
      wait_bytes(n + exp_q.size(), 2 * BYTE);
    end
    wait_bytes(n + exp_q.size() + 1, BYTE);
    check("rand_count", rx_q.size() - n, exp_q.size());
    foreach (exp_q[k]) check($sformatf("rand_byte%0d", k), rx_at(n + k), exp_q[k]);

    n = rx_q.size();
    send_frame(8'h1C);
    send_frame(8'h32);
    send_frame(8'h21);
    low = 0;
    while (tx !== 1'b0 && low < BYTE) begin
      @(negedge clk);
      low++;
    end
    check("tx_low_before_reset", tx, 0);
    reset = 0;
    #1;
    check("reset_abort_tx", tx, 1);
    repeat (5) @(negedge clk);
    reset = 1;
    low = 0;
    repeat (2 * BYTE) begin
      @(negedge clk);
      if (tx !== 1'b1) low++;
    end
    check("post_reset_low", low, 0);
    check("post_reset_bytes", rx_q.size() - n, 0);
    send_frame(8'h5A);
    wait_bytes(n + 2, 2 * BYTE);
    check("post_reset_count", rx_q.size() - n, 1);
    check("post_reset_byte", rx_at(n), 8'h0D);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
